// File: rtl/sram_ext_pkg.sv
// Shared definitions for the parametrised lane-masked single-port SRAM model.
// Holds the controller state encoding, the lane-width helper and the
// parameter legality function evaluated at elaboration time by the top.
package sram_ext_pkg;

  // Controller state: zeroing sweep after reset, then normal service.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sram_state_e;

  // Width of one write lane.
  function automatic int unsigned lane_bits(input int unsigned data_bits,
                                            input int unsigned mask_bits);
    return (mask_bits == 0) ? 0 : data_bits / mask_bits;
  endfunction

  // True when the geometry and latency parameters describe a buildable array.
  function automatic bit params_legal(input int unsigned addr_bits,
                                      input int unsigned depth,
                                      input int unsigned data_bits,
                                      input int unsigned mask_bits,
                                      input int unsigned read_latency);
    bit ok;
    ok = 1'b1;
    if (mask_bits == 0 || data_bits == 0 || (data_bits % mask_bits) != 0) ok = 1'b0;
    if (addr_bits == 0 || addr_bits > 31) ok = 1'b0;
    else if (depth < 2 || depth > (32'd1 << addr_bits)) ok = 1'b0;
    if (read_latency < 1 || read_latency > 2) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline: LATENCY register stages of valid + data.
// Data stages load only when their incoming valid is set, so the last stage
// holds the most recent read word between pulses. Async reset clears all.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid, in_data read word captured at accept
//   out_valid         one-cycle pulse LATENCY cycles after in_valid
//   out_data          returned word, held between pulses
module sram_rd_pipe #(
  parameter int unsigned DATA_BITS = 200,
  parameter int unsigned LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data
);

  logic                 vld_q [LATENCY];
  logic [DATA_BITS-1:0] dat_q [LATENCY];

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_first
      // First stage takes the word read from the array at accept.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q[0] <= 1'b0;
          dat_q[0] <= '0;
        end else begin
          vld_q[0] <= in_valid;
          if (in_valid) dat_q[0] <= in_data;
        end
      end
    end else begin : g_next
      // Later stages forward only valid words, preserving held data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q[g] <= 1'b0;
          dat_q[g] <= '0;
        end else begin
          vld_q[g] <= vld_q[g-1];
          if (vld_q[g-1]) dat_q[g] <= dat_q[g-1];
        end
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/masked_sram_1rw_ext.sv
// Parametrised single-port lane-masked SRAM behavioural model.
// After reset an optional zeroing sweep runs before requests are accepted.
// Reads return through a fixed-latency pipeline with a valid strobe and held
// data; out-of-range reads return zero, out-of-range writes are dropped.
// Ports:
//   RW0_clk, RW0_reset_n  clock, asynchronous active-low reset
//   RW0_en, RW0_wmode     request strobe, 1 = write / 0 = read
//   RW0_addr              word address
//   RW0_wmask, RW0_wdata  per-lane write enables and write data
//   RW0_ready             array accepts requests
//   RW0_rvalid, RW0_rdata read return pulse and held read data
module masked_sram_1rw_ext
  import sram_ext_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 3,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DATA_BITS    = 200,
  parameter int unsigned MASK_BITS    = 2,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned INIT_ZERO    = 1
) (
  input  logic                 RW0_clk,
  input  logic                 RW0_reset_n,
  input  logic                 RW0_en,
  input  logic                 RW0_wmode,
  input  logic [ADDR_BITS-1:0] RW0_addr,
  input  logic [MASK_BITS-1:0] RW0_wmask,
  input  logic [DATA_BITS-1:0] RW0_wdata,
  output logic                 RW0_ready,
  output logic                 RW0_rvalid,
  output logic [DATA_BITS-1:0] RW0_rdata
);

  localparam int unsigned          LANE      = lane_bits(DATA_BITS, MASK_BITS);
  localparam int unsigned          IDX_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
  localparam logic [ADDR_BITS:0]   DEPTH_W   = (ADDR_BITS + 1)'(DEPTH);
  localparam bit                   DO_INIT   = (INIT_ZERO != 0);

  if (!params_legal(ADDR_BITS, DEPTH, DATA_BITS, MASK_BITS, READ_LATENCY)) begin : g_bad_params
    $error("masked_sram_1rw_ext: illegal ADDR_BITS/DEPTH/DATA_BITS/MASK_BITS/READ_LATENCY");
  end

  sram_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0] init_cnt_q, init_cnt_d;
  logic                 ready_q, ready_d;
  logic                 init_we_c;

  logic                 addr_in_range_c;
  logic [IDX_BITS-1:0]  addr_idx_c;
  logic                 wr_acc_c;
  logic                 rd_acc_c;
  logic [DATA_BITS-1:0] rd_word_c;

  logic [DATA_BITS-1:0] mem [DEPTH];

  // State, sweep counter and ready flag.
  always_ff @(posedge RW0_clk or negedge RW0_reset_n) begin
    if (!RW0_reset_n) begin
      state_q    <= DO_INIT ? ST_INIT : ST_RUN;
      init_cnt_q <= '0;
      ready_q    <= !DO_INIT;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
    end
  end

  // Next state: INIT writes one zero word per cycle, leaves after the last.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_we_c  = 1'b0;
    ready_d    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        init_we_c = 1'b1;
        if (init_cnt_q == LAST_ADDR) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + ADDR_BITS'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
    endcase
    // Ready follows the state it will be in after this edge.
    ready_d = (state_d == ST_RUN);
  end

  // Request decode.
  always_comb begin
    addr_in_range_c = ({1'b0, RW0_addr} < DEPTH_W);
    addr_idx_c      = IDX_BITS'(RW0_addr);
    wr_acc_c        = RW0_en && ready_q && RW0_wmode;
    rd_acc_c        = RW0_en && ready_q && !RW0_wmode;
    rd_word_c       = '0;
    if (addr_in_range_c) rd_word_c = mem[addr_idx_c];
  end

  // Array write port: zeroing sweep or lane-masked user write.
  always_ff @(posedge RW0_clk) begin
    if (init_we_c) begin
      mem[IDX_BITS'(init_cnt_q)] <= '0;
    end else if (wr_acc_c && addr_in_range_c) begin
      for (int unsigned i = 0; i < MASK_BITS; i++) begin
        if (RW0_wmask[i]) mem[addr_idx_c][i*LANE +: LANE] <= RW0_wdata[i*LANE +: LANE];
      end
    end
  end

  sram_rd_pipe #(
    .DATA_BITS (DATA_BITS),
    .LATENCY   (READ_LATENCY)
  ) u_rd_pipe (
    .clk       (RW0_clk),
    .rst_n     (RW0_reset_n),
    .in_valid  (rd_acc_c),
    .in_data   (rd_word_c),
    .out_valid (RW0_rvalid),
    .out_data  (RW0_rdata)
  );

  assign RW0_ready = ready_q;

endmodule

// File: tb/tb_masked_sram_1rw_ext.sv
// Directed bench: instance A is the default 8x200 / 2-lane / latency-1 array
// with zeroing; instance B is a 6-deep latency-2 array without zeroing.
module tb_masked_sram_1rw_ext;

  localparam int unsigned DW = 200;

  logic clk;
  int   errors;
  int   checks;

  // Instance A signals.
  logic          a_rst_n, a_en, a_wmode, a_ready, a_rvalid;
  logic [2:0]    a_addr;
  logic [1:0]    a_wmask;
  logic [DW-1:0] a_wdata, a_rdata;

  // Instance B signals.
  logic          b_rst_n, b_en, b_wmode, b_ready, b_rvalid;
  logic [2:0]    b_addr;
  logic [1:0]    b_wmask;
  logic [DW-1:0] b_wdata, b_rdata;

  // Reference words.
  logic [DW-1:0] pat_a5, pat_5a, pat_3c, pat_77, d0, d1, d2, hi_only;

  masked_sram_1rw_ext #(
    .ADDR_BITS(3), .DEPTH(8), .DATA_BITS(DW), .MASK_BITS(2),
    .READ_LATENCY(1), .INIT_ZERO(1)
  ) u_a (
    .RW0_clk(clk), .RW0_reset_n(a_rst_n), .RW0_en(a_en), .RW0_wmode(a_wmode),
    .RW0_addr(a_addr), .RW0_wmask(a_wmask), .RW0_wdata(a_wdata),
    .RW0_ready(a_ready), .RW0_rvalid(a_rvalid), .RW0_rdata(a_rdata)
  );

  masked_sram_1rw_ext #(
    .ADDR_BITS(3), .DEPTH(6), .DATA_BITS(DW), .MASK_BITS(2),
    .READ_LATENCY(2), .INIT_ZERO(0)
  ) u_b (
    .RW0_clk(clk), .RW0_reset_n(b_rst_n), .RW0_en(b_en), .RW0_wmode(b_wmode),
    .RW0_addr(b_addr), .RW0_wmask(b_wmask), .RW0_wdata(b_wdata),
    .RW0_ready(b_ready), .RW0_rvalid(b_rvalid), .RW0_rdata(b_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; drive and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [2:0] addr, input logic [1:0] mask, input logic [DW-1:0] data);
    a_en = 1'b1; a_wmode = 1'b1; a_addr = addr; a_wmask = mask; a_wdata = data;
    tick();
    a_en = 1'b0; a_wmode = 1'b0;
  endtask

  task automatic a_read(input logic [2:0] addr, output logic vld, output logic [DW-1:0] data);
    a_en = 1'b1; a_wmode = 1'b0; a_addr = addr;
    tick();
    a_en = 1'b0;
    vld = a_rvalid; data = a_rdata;
  endtask

  task automatic b_write(input logic [2:0] addr, input logic [1:0] mask, input logic [DW-1:0] data);
    b_en = 1'b1; b_wmode = 1'b1; b_addr = addr; b_wmask = mask; b_wdata = data;
    tick();
    b_en = 1'b0; b_wmode = 1'b0;
  endtask

  task automatic b_read(input logic [2:0] addr, output logic vld, output logic [DW-1:0] data);
    b_en = 1'b1; b_wmode = 1'b0; b_addr = addr;
    tick();
    b_en = 1'b0;
    tick();
    vld = b_rvalid; data = b_rdata;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready: got %b want 0", a_ready); end
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rst_a_rvalid: got %b want 0", a_rvalid); end
    checks++; if (a_rdata !== '0) begin errors++; $display("FAIL rst_a_rdata: got %h want 0", a_rdata); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready: got %b want 1", b_ready); end
    checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL rst_b_rvalid: got %b want 0", b_rvalid); end
    checks++; if (b_rdata !== '0) begin errors++; $display("FAIL rst_b_rdata: got %h want 0", b_rdata); end
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
  endtask

  // Writes of all-ones are driven throughout INIT and must be ignored.
  task automatic test_init_ignored();
    int n;
    n = 0;
    while (a_ready !== 1'b1 && n < 40) begin
      a_en = 1'b1; a_wmode = 1'b1; a_addr = 3'(n); a_wmask = 2'b11; a_wdata = '1;
      tick();
      n++;
    end
    a_en = 1'b0; a_wmode = 1'b0;
    checks++; if (n != 8) begin errors++; $display("FAIL init_cycles: got %0d want 8", n); end
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL init_rvalid: got %b want 0", a_rvalid); end
  endtask

  // Back-to-back reads of every address after INIT return zero, one cycle later.
  task automatic test_read_all_zero();
    for (int i = 0; i < 8; i++) begin
      a_en = 1'b1; a_wmode = 1'b0; a_addr = 3'(i);
      tick();
      checks++; if (a_rvalid !== 1'b1) begin errors++; $display("FAIL zero_rvalid%0d: got %b want 1", i, a_rvalid); end
      checks++; if (a_rdata !== '0) begin errors++; $display("FAIL zero_rdata%0d: got %h want 0", i, a_rdata); end
    end
    a_en = 1'b0;
    tick();
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL zero_pulse_end: got %b want 0", a_rvalid); end
  endtask

  task automatic test_masked_write();
    logic          vld;
    logic [DW-1:0] data;
    a_write(3'd3, 2'b11, '1);
    a_write(3'd3, 2'b01, '0);
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL mask_wr_rvalid: got %b want 0", a_rvalid); end
    a_read(3'd3, vld, data);
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL mask_rvalid: got %b want 1", vld); end
    checks++; if (data !== hi_only) begin errors++; $display("FAIL mask_rdata: got %h want %h", data, hi_only); end
    // Zero mask is a no-op.
    a_write(3'd3, 2'b00, '0);
    a_read(3'd3, vld, data);
    checks++; if (data !== hi_only) begin errors++; $display("FAIL mask_none: got %h want %h", data, hi_only); end
  endtask

  task automatic test_write_read_hazard();
    logic          vld;
    logic [DW-1:0] data;
    a_write(3'd5, 2'b11, pat_a5);
    a_read(3'd5, vld, data);
    checks++; if (vld !== 1'b1 || data !== pat_a5) begin errors++; $display("FAIL hazard: got v=%b %h want v=1 %h", vld, data, pat_a5); end
    a_write(3'd6, 2'b11, pat_5a);
    a_write(3'd5, 2'b10, '0);
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL hold_rvalid: got %b want 0", a_rvalid); end
    checks++; if (a_rdata !== pat_a5) begin errors++; $display("FAIL hold_rdata: got %h want %h", a_rdata, pat_a5); end
    a_read(3'd6, vld, data);
    checks++; if (data !== pat_5a) begin errors++; $display("FAIL read6: got %h want %h", data, pat_5a); end
  endtask

  // Latency-2 instance: three consecutive reads return on three consecutive cycles.
  task automatic test_back_to_back();
    b_write(3'd0, 2'b11, d0);
    b_write(3'd1, 2'b11, d1);
    b_write(3'd2, 2'b11, d2);
    checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_wr_rvalid: got %b want 0", b_rvalid); end
    b_en = 1'b1; b_wmode = 1'b0; b_addr = 3'd0;
    tick();
    checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_early: got %b want 0", b_rvalid); end
    b_addr = 3'd1;
    tick();
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== d0) begin errors++; $display("FAIL b2b_r0: got v=%b %h want v=1 %h", b_rvalid, b_rdata, d0); end
    b_addr = 3'd2;
    tick();
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== d1) begin errors++; $display("FAIL b2b_r1: got v=%b %h want v=1 %h", b_rvalid, b_rdata, d1); end
    b_en = 1'b0;
    tick();
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== d2) begin errors++; $display("FAIL b2b_r2: got v=%b %h want v=1 %h", b_rvalid, b_rdata, d2); end
    tick();
    checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", b_rvalid); end
    checks++; if (b_rdata !== d2) begin errors++; $display("FAIL b2b_hold: got %h want %h", b_rdata, d2); end
  endtask

  task automatic test_out_of_range();
    logic          vld;
    logic [DW-1:0] data;
    b_write(3'd7, 2'b11, '1);
    b_read(3'd7, vld, data);
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL oor_rvalid: got %b want 1", vld); end
    checks++; if (data !== '0) begin errors++; $display("FAIL oor_rdata: got %h want 0", data); end
    b_read(3'd1, vld, data);
    checks++; if (data !== d1) begin errors++; $display("FAIL oor_alias: got %h want %h", data, d1); end
  endtask

  task automatic test_reset_mid_read_a();
    logic          vld;
    logic [DW-1:0] data;
    int            n;
    a_write(3'd2, 2'b11, pat_3c);
    a_read(3'd2, vld, data);
    checks++; if (data !== pat_3c) begin errors++; $display("FAIL rmid_a_pre: got %h want %h", data, pat_3c); end
    a_rst_n = 1'b0;
    #1;
    checks++; if (a_rvalid !== 1'b0 || a_rdata !== '0) begin errors++; $display("FAIL rmid_a_out: got v=%b %h want v=0 0", a_rvalid, a_rdata); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rmid_a_ready: got %b want 0", a_ready); end
    tick(); tick();
    a_rst_n = 1'b1;
    n = 0;
    while (a_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL rmid_a_init: got %0d want 8", n); end
    a_read(3'd2, vld, data);
    checks++; if (vld !== 1'b1 || data !== '0) begin errors++; $display("FAIL rmid_a_z2: got v=%b %h want v=1 0", vld, data); end
    a_read(3'd5, vld, data);
    checks++; if (data !== '0) begin errors++; $display("FAIL rmid_a_z5: got %h want 0", data); end
  endtask

  task automatic test_reset_mid_read_b();
    logic          vld;
    logic [DW-1:0] data;
    b_write(3'd3, 2'b11, pat_77);
    b_en = 1'b1; b_wmode = 1'b0; b_addr = 3'd3;
    tick();
    b_en = 1'b0;
    b_rst_n = 1'b0;
    #1;
    checks++; if (b_rvalid !== 1'b0 || b_rdata !== '0) begin errors++; $display("FAIL rmid_b_out: got v=%b %h want v=0 0", b_rvalid, b_rdata); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rmid_b_ready: got %b want 1", b_ready); end
    tick(); tick();
    b_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_b_flush%0d: got %b want 0", i, b_rvalid); end
    end
    b_read(3'd3, vld, data);
    checks++; if (vld !== 1'b1 || data !== pat_77) begin errors++; $display("FAIL rmid_b_keep3: got v=%b %h want v=1 %h", vld, data, pat_77); end
    b_read(3'd1, vld, data);
    checks++; if (data !== d1) begin errors++; $display("FAIL rmid_b_keep1: got %h want %h", data, d1); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    pat_a5  = {25{8'hA5}};
    pat_5a  = {25{8'h5A}};
    pat_3c  = {25{8'h3C}};
    pat_77  = {25{8'h77}};
    d0      = {25{8'h11}};
    d1      = {25{8'h22}};
    d2      = {25{8'h33}};
    hi_only = {{100{1'b1}}, {100{1'b0}}};
    a_rst_n = 1'b0; a_en = 1'b0; a_wmode = 1'b0; a_addr = '0; a_wmask = '0; a_wdata = '0;
    b_rst_n = 1'b0; b_en = 1'b0; b_wmode = 1'b0; b_addr = '0; b_wmask = '0; b_wdata = '0;

    test_reset();
    test_init_ignored();
    test_read_all_zero();
    test_masked_write();
    test_write_read_hazard();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_read_a();
    test_reset_mid_read_b();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
